// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer driving a shared ALU (restoring division).
// Optional ALU_DIV_ZERO_SKIP_EN: zero dividend with nonzero divisor finishes immediately with result 0.
module alu_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result
);
  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, CMP, SUB, FIX, DONE} state_t;
  localparam logic [3:0] ADD = 4'b0000, SUBC = 4'b0001, GEU = 4'b1010;
  state_t state, state_n;
  logic [31:0] a_q, b_q, q, r, d, s;
  logic [1:0]  op_q;
  logic [4:0]  cnt;
  logic        sgn, neg_a, neg_b, neg_q, ge, zero_skip;
  assign sgn   = ~op_q[0];
  assign neg_a = sgn & a_q[31];
  assign neg_b = sgn & b_q[31];
  assign neg_q = neg_a ^ neg_b;
  assign s     = {r[30:0], q[31]};
  // r[31] set means the shifted remainder has a 33rd bit, so it exceeds d regardless of the compare
  assign ge    = r[31] | alu_result[0];
  assign busy  = state != IDLE;
  assign done  = state == DONE;
`ifdef ALU_DIV_ZERO_SKIP_EN
  assign zero_skip = dividend == '0;
`else
  assign zero_skip = 1'b0;
`endif
  always_comb begin
    state_n  = state;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ADD;
    case (state)
      IDLE:  state_n = start ? ((divisor == '0 || zero_skip) ? DONE : NEG_A) : IDLE;
      NEG_A: begin alu_b = a_q; alu_ctrl = SUBC; state_n = NEG_B; end
      NEG_B: begin alu_b = b_q; alu_ctrl = SUBC; state_n = CMP; end
      CMP: begin
        alu_a    = s;
        alu_b    = d;
        alu_ctrl = GEU;
        state_n  = ge ? SUB : (cnt == '0 ? FIX : CMP);
      end
      SUB: begin
        alu_a    = r;
        alu_b    = d;
        alu_ctrl = SUBC;
        state_n  = cnt == '0 ? FIX : CMP;
      end
      FIX:   begin alu_b = op_q[1] ? r : q; alu_ctrl = SUBC; state_n = DONE; end
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      op_q   <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          a_q  <= dividend;
          b_q  <= divisor;
          op_q <= op;
          cnt  <= 5'd31;
          if (divisor == '0) result <= op[1] ? dividend : '1;
          else if (zero_skip) result <= '0;
        end
        NEG_A: begin
          q <= neg_a ? alu_result : a_q;
          r <= '0;
        end
        NEG_B: d <= neg_b ? alu_result : b_q;
        CMP: begin
          r <= s;
          q <= {q[30:0], ge};
          if (!ge && cnt != '0) cnt <= cnt - 5'd1;
        end
        SUB: begin
          r <= alu_result;
          if (cnt != '0) cnt <= cnt - 5'd1;
        end
        FIX: result <= op_q[1] ? (neg_a ? alu_result : r) : (neg_q ? alu_result : q);
        default: ;
      endcase
    end
  end
endmodule
